// File: rtl/core_if_fetch_if.sv
// Fetch-stage handshake bundle: instruction bus read channel plus the
// valid/ready channel towards decode. master = fetch stage, slave = bus/decode side.
interface core_if_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              ibus_req_o;
    logic [ADDR_W-1:0] ibus_addr_o;
    logic              ibus_ack_i;
    logic [INST_W-1:0] ibus_rdata_i;
    logic              id_valid_out;
    logic              id_ready_in;
    logic [INST_W-1:0] id_inst_out;
    logic [ADDR_W-1:0] id_inst_addr_out;

    modport master (
        output ibus_req_o, ibus_addr_o, id_valid_out, id_inst_out, id_inst_addr_out,
        input  ibus_ack_i, ibus_rdata_i, id_ready_in
    );

    modport slave (
        input  ibus_req_o, ibus_addr_o, id_valid_out, id_inst_out, id_inst_addr_out,
        output ibus_ack_i, ibus_rdata_i, id_ready_in
    );
endinterface

// File: rtl/core_if_fetch.sv
// Instruction fetch stage: one outstanding bus read, one-entry output buffer to decode,
// and flush on jump. hold_out stalls the PC register whenever a new PC cannot be taken.
//
// state | meaning
// IDLE  | no outstanding request
// WAIT  | request outstanding
// VALID | instruction buffered for decode
// DRAIN | request outstanding, result will be discarded
module core_if_fetch #(
    parameter int              ADDR_W   = 32,
    parameter int              INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc_in,
    input  logic                jump_flag_in,
    output logic                hold_out,
    core_if_fetch_if.master     bus
);
    typedef enum logic [1:0] {IDLE, WAIT, VALID, DRAIN} state_t;

    state_t state;
    logic   accept;

    assign accept = !rst && !jump_flag_in &&
                    (state == IDLE || (state == VALID && bus.id_ready_in));
    assign hold_out = !accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            bus.ibus_req_o       <= 1'b0;
            bus.ibus_addr_o      <= '0;
            bus.id_valid_out     <= 1'b0;
            bus.id_inst_out      <= NOP_INST;
            bus.id_inst_addr_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.ibus_addr_o <= pc_in;
                        bus.ibus_req_o  <= 1'b1;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.ibus_ack_i) begin
                        bus.ibus_req_o <= 1'b0;
                        if (jump_flag_in) begin
                            state <= IDLE;
                        end else begin
                            bus.id_inst_out      <= bus.ibus_rdata_i;
                            bus.id_inst_addr_out <= bus.ibus_addr_o;
                            bus.id_valid_out     <= 1'b1;
                            state                <= VALID;
                        end
                    end else if (jump_flag_in) begin
                        // bus read cannot be aborted; keep req up and drop the result later
                        state <= DRAIN;
                    end
                end
                VALID: begin
                    if (jump_flag_in) begin
                        bus.id_valid_out <= 1'b0;
                        bus.id_inst_out  <= NOP_INST;
                        state            <= IDLE;
                    end else if (accept) begin
                        bus.id_valid_out <= 1'b0;
                        bus.id_inst_out  <= NOP_INST;
                        bus.ibus_addr_o  <= pc_in;
                        bus.ibus_req_o   <= 1'b1;
                        state            <= WAIT;
                    end
                end
                DRAIN: begin
                    if (bus.ibus_ack_i) begin
                        bus.ibus_req_o <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_if_fetch.sv
// Self-checking bench for core_if_fetch: directed timing scenarios plus a randomized
// run against a PC-register / fetch-queue reference model.
module tb_core_if_fetch;
    localparam int          AW  = 32;
    localparam int          IW  = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          jump;
    logic          hold;
    logic [AW-1:0] pc;
    int            errors = 0;
    int            checks = 0;

    core_if_fetch_if #(.ADDR_W(AW), .INST_W(IW)) f ();

    core_if_fetch #(.ADDR_W(AW), .INST_W(IW), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc),
        .jump_flag_in (jump),
        .hold_out     (hold),
        .bus          (f.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; jump = 1'b0; pc = '0;
        f.id_ready_in = 1'b0; f.ibus_ack_i = 1'b0; f.ibus_rdata_i = '0;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; jump = 1'b0; pc = 32'h1234;
        f.id_ready_in = 1'b1; f.ibus_ack_i = 1'b0; f.ibus_rdata_i = '0;
        repeat (2) cyc();
        #1;
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b want 1", hold); end
        checks++; if (f.ibus_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", f.ibus_req_o); end
        checks++; if (f.ibus_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", f.ibus_addr_o); end
        checks++; if (f.id_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", f.id_valid_out); end
        checks++; if (f.id_inst_out !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", f.id_inst_out, NOP); end
        checks++; if (f.id_inst_addr_out !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h want 0", f.id_inst_addr_out); end
    endtask

    task automatic test_single_fetch();
        do_reset();
        #1;
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL single_idle_hold: got %b want 0", hold); end
        cyc();
        checks++; if (f.ibus_req_o !== 1'b1 || f.ibus_addr_o !== 32'h0) begin errors++; $display("FAIL single_req: got req=%b addr=%h want req=1 addr=0", f.ibus_req_o, f.ibus_addr_o); end
        #1;
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL single_wait_hold: got %b want 1", hold); end
        f.ibus_ack_i = 1'b1; f.ibus_rdata_i = 32'h0050_0093;
        cyc();
        f.ibus_ack_i = 1'b0;
        checks++; if (f.id_valid_out !== 1'b1 || f.id_inst_out !== 32'h0050_0093 || f.id_inst_addr_out !== 32'h0)
            begin errors++; $display("FAIL single_valid: got v=%b inst=%h addr=%h want v=1 inst=00500093 addr=0", f.id_valid_out, f.id_inst_out, f.id_inst_addr_out); end
        checks++; if (f.ibus_req_o !== 1'b0) begin errors++; $display("FAIL single_req_drop: got %b want 0", f.ibus_req_o); end
        #1;
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL single_valid_hold: got %b want 1", hold); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] gaddr [3];
        int          gcyc  [3];
        int          got;
        int          t;
        logic        ph;
        do_reset();
        pc = 32'h0; f.id_ready_in = 1'b1; got = 0; t = 0;
        #1 ph = hold;
        for (int c = 0; c < 20 && got < 3; c++) begin
            cyc(); t++;
            if (!ph) pc = pc + 32'd4;
            if (f.id_valid_out) begin
                gaddr[got] = f.id_inst_addr_out; gcyc[got] = t;
                checks++; if (f.id_inst_out !== mem(32'(4 * got))) begin errors++; $display("FAIL b2b_inst%0d: got %h want %h", got, f.id_inst_out, mem(32'(4 * got))); end
                got++;
            end
            f.ibus_ack_i = f.ibus_req_o; f.ibus_rdata_i = mem(f.ibus_addr_o);
            #1 ph = hold;
        end
        f.ibus_ack_i = 1'b0; f.id_ready_in = 1'b0;
        checks++; if (got !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", got); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (gaddr[i] !== 32'(4 * i)) begin errors++; $display("FAIL b2b_addr%0d: got %h want %h", i, gaddr[i], 32'(4 * i)); end
            end
            checks++; if (gcyc[1] - gcyc[0] !== 2 || gcyc[2] - gcyc[1] !== 2)
                begin errors++; $display("FAIL b2b_spacing: got %0d,%0d want 2,2", gcyc[1] - gcyc[0], gcyc[2] - gcyc[1]); end
        end
    endtask

    task automatic test_decode_stall();
        do_reset();
        pc = 32'h40;
        cyc();
        pc = 32'h44;
        f.ibus_ack_i = 1'b1; f.ibus_rdata_i = mem(32'h40);
        cyc();
        f.ibus_ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (f.id_valid_out !== 1'b1 || f.id_inst_out !== mem(32'h40) || f.id_inst_addr_out !== 32'h40 || f.ibus_req_o !== 1'b0)
                begin errors++; $display("FAIL stall_stable%0d: got v=%b inst=%h addr=%h req=%b", i, f.id_valid_out, f.id_inst_out, f.id_inst_addr_out, f.ibus_req_o); end
            #1;
            checks++; if (hold !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: got %b want 1", i, hold); end
            cyc();
        end
        f.id_ready_in = 1'b1;
        #1;
        checks++; if (hold !== 1'b0 || f.id_valid_out !== 1'b1) begin errors++; $display("FAIL stall_release: got hold=%b v=%b want hold=0 v=1", hold, f.id_valid_out); end
        cyc();
        f.id_ready_in = 1'b0;
        checks++; if (f.ibus_req_o !== 1'b1 || f.ibus_addr_o !== 32'h44 || f.id_valid_out !== 1'b0)
            begin errors++; $display("FAIL stall_next_req: got req=%b addr=%h v=%b want 1 44 0", f.ibus_req_o, f.ibus_addr_o, f.id_valid_out); end
    endtask

    task automatic test_jump_wait();
        do_reset();
        pc = 32'h80; f.id_ready_in = 1'b1;
        cyc();
        pc = 32'h84; jump = 1'b1;
        #1;
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL jw_hold_jump: got %b want 1", hold); end
        cyc();
        jump = 1'b0; pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            checks++; if (f.ibus_req_o !== 1'b1 || f.ibus_addr_o !== 32'h80 || f.id_valid_out !== 1'b0)
                begin errors++; $display("FAIL jw_drain%0d: got req=%b addr=%h v=%b want 1 80 0", i, f.ibus_req_o, f.ibus_addr_o, f.id_valid_out); end
            if (i == 2) begin f.ibus_ack_i = 1'b1; f.ibus_rdata_i = 32'hDEAD_BEEF; end
            #1;
            checks++; if (hold !== 1'b1) begin errors++; $display("FAIL jw_drain_hold%0d: got %b want 1", i, hold); end
            cyc();
        end
        f.ibus_ack_i = 1'b0;
        checks++; if (f.id_valid_out !== 1'b0 || f.ibus_req_o !== 1'b0 || f.id_inst_out === 32'hDEAD_BEEF)
            begin errors++; $display("FAIL jw_discard: got v=%b req=%b inst=%h", f.id_valid_out, f.ibus_req_o, f.id_inst_out); end
        #1;
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL jw_idle_hold: got %b want 0", hold); end
        cyc();
        checks++; if (f.ibus_req_o !== 1'b1 || f.ibus_addr_o !== 32'h200) begin errors++; $display("FAIL jw_target_req: got req=%b addr=%h want 1 200", f.ibus_req_o, f.ibus_addr_o); end
        pc = 32'h204;
        f.ibus_ack_i = 1'b1; f.ibus_rdata_i = mem(32'h200);
        cyc();
        f.ibus_ack_i = 1'b0; f.id_ready_in = 1'b0;
        checks++; if (f.id_valid_out !== 1'b1 || f.id_inst_addr_out !== 32'h200 || f.id_inst_out !== mem(32'h200))
            begin errors++; $display("FAIL jw_target_data: got v=%b addr=%h inst=%h", f.id_valid_out, f.id_inst_addr_out, f.id_inst_out); end
    endtask

    task automatic test_jump_valid();
        do_reset();
        pc = 32'h300;
        cyc();
        pc = 32'h304; f.ibus_ack_i = 1'b1; f.ibus_rdata_i = mem(32'h300);
        cyc();
        f.ibus_ack_i = 1'b0;
        checks++; if (f.id_valid_out !== 1'b1) begin errors++; $display("FAIL jv_valid: got %b want 1", f.id_valid_out); end
        jump = 1'b1;
        #1;
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL jv_hold: got %b want 1", hold); end
        cyc();
        jump = 1'b0; pc = 32'h400;
        checks++; if (f.id_valid_out !== 1'b0 || f.id_inst_out !== NOP) begin errors++; $display("FAIL jv_flush: got v=%b inst=%h want 0 %h", f.id_valid_out, f.id_inst_out, NOP); end
        #1;
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL jv_idle: got hold=%b want 0", hold); end
        cyc();
        checks++; if (f.ibus_req_o !== 1'b1 || f.ibus_addr_o !== 32'h400) begin errors++; $display("FAIL jv_req: got req=%b addr=%h want 1 400", f.ibus_req_o, f.ibus_addr_o); end
        jump = 1'b1; f.ibus_ack_i = 1'b1; f.ibus_rdata_i = 32'hCAFE_F00D;
        cyc();
        jump = 1'b0; f.ibus_ack_i = 1'b0; pc = 32'h500;
        checks++; if (f.id_valid_out !== 1'b0 || f.ibus_req_o !== 1'b0) begin errors++; $display("FAIL jv_ack_jump: got v=%b req=%b want 0 0", f.id_valid_out, f.ibus_req_o); end
        #1;
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL jv_ack_jump_idle: got hold=%b want 0", hold); end
        cyc();
        checks++; if (f.ibus_req_o !== 1'b1 || f.ibus_addr_o !== 32'h500 || f.id_valid_out !== 1'b0)
            begin errors++; $display("FAIL jv_after: got req=%b addr=%h v=%b want 1 500 0", f.ibus_req_o, f.ibus_addr_o, f.id_valid_out); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        pc = 32'h600;
        cyc();
        checks++; if (f.ibus_req_o !== 1'b1) begin errors++; $display("FAIL rw_req: got %b want 1", f.ibus_req_o); end
        rst = 1'b1;
        cyc();
        checks++; if (f.ibus_req_o !== 1'b0 || f.id_valid_out !== 1'b0) begin errors++; $display("FAIL rw_drop: got req=%b v=%b want 0 0", f.ibus_req_o, f.id_valid_out); end
        #1;
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL rw_hold_rst: got %b want 1", hold); end
        rst = 1'b0; f.ibus_ack_i = 1'b1; f.ibus_rdata_i = 32'h1111_2222;
        #1;
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL rw_idle: got hold=%b want 0", hold); end
        cyc();
        f.ibus_ack_i = 1'b0;
        checks++; if (f.id_valid_out !== 1'b0 || f.ibus_req_o !== 1'b1 || f.ibus_addr_o !== 32'h600)
            begin errors++; $display("FAIL rw_late_ack: got v=%b req=%b addr=%h want 0 1 600", f.id_valid_out, f.ibus_req_o, f.ibus_addr_o); end
        cyc();
        checks++; if (f.id_valid_out !== 1'b0 || f.ibus_req_o !== 1'b1) begin errors++; $display("FAIL rw_after: got v=%b req=%b want 0 1", f.id_valid_out, f.ibus_req_o); end
    endtask

    // Reference: PC register model + queue of fetched-but-undelivered PCs; a jump empties it.
    task automatic test_random();
        logic [31:0] pend [$];
        logic [31:0] target, piaddr, pinst, paddr, front;
        logic        ph, pj, pr, pv, preq, pack;
        int          lat, delivered;
        do_reset();
        lat = -1; delivered = 0; target = '0;
        #1;
        ph = hold; pj = 1'b0; pr = 1'b0; pv = 1'b0; preq = 1'b0; pack = 1'b0; paddr = '0; piaddr = '0; pinst = '0;
        for (int c = 0; c < 400; c++) begin
            cyc();
            if (pv && pr && !pj) begin
                checks++;
                if (pend.size() == 0) begin errors++; $display("FAIL rnd_unexpected_delivery: addr=%h with nothing outstanding", piaddr); end
                else begin
                    front = pend.pop_front();
                    if (piaddr !== front || pinst !== mem(front)) begin errors++; $display("FAIL rnd_delivery: got addr=%h inst=%h want addr=%h inst=%h", piaddr, pinst, front, mem(front)); end
                end
                delivered++;
            end
            if (pj) begin
                pend.delete();
                pc = target;
            end else if (!ph) begin
                pend.push_back(pc);
                checks++; if (f.ibus_req_o !== 1'b1 || f.ibus_addr_o !== pc) begin errors++; $display("FAIL rnd_issue: got req=%b addr=%h want 1 %h", f.ibus_req_o, f.ibus_addr_o, pc); end
                pc = pc + 32'd4;
            end
            if (preq && !pack) begin
                checks++; if (f.ibus_req_o !== 1'b1 || f.ibus_addr_o !== paddr) begin errors++; $display("FAIL rnd_req_held: got req=%b addr=%h want 1 %h", f.ibus_req_o, f.ibus_addr_o, paddr); end
            end
            if (f.id_valid_out) begin
                checks++; if (f.id_inst_out !== mem(f.id_inst_addr_out)) begin errors++; $display("FAIL rnd_valid_data: got inst=%h for addr=%h", f.id_inst_out, f.id_inst_addr_out); end
            end
            f.id_ready_in = ($urandom % 10) < 7;
            jump = ($urandom % 20) == 0;
            target = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if (f.ibus_req_o) begin
                if (lat < 0) lat = int'($urandom_range(0, 3));
                if (lat == 0) begin f.ibus_ack_i = 1'b1; f.ibus_rdata_i = mem(f.ibus_addr_o); lat = -1; end
                else begin f.ibus_ack_i = 1'b0; f.ibus_rdata_i = $urandom; lat--; end
            end else begin
                f.ibus_ack_i = 1'b0; lat = -1;
            end
            #1;
            if (jump) begin
                checks++; if (hold !== 1'b1) begin errors++; $display("FAIL rnd_jump_hold: got %b want 1", hold); end
            end
            ph = hold; pj = jump; pr = f.id_ready_in; pv = f.id_valid_out;
            piaddr = f.id_inst_addr_out; pinst = f.id_inst_out;
            preq = f.ibus_req_o; paddr = f.ibus_addr_o; pack = f.ibus_ack_i;
        end
        jump = 1'b0; f.ibus_ack_i = 1'b0; f.id_ready_in = 1'b0;
        checks++; if (delivered < 20) begin errors++; $display("FAIL rnd_throughput: got %0d deliveries want at least 20", delivered); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_decode_stall();
        test_jump_wait();
        test_jump_valid();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
